// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button input path: debounce FSM encoding
// and default debounce/auto-repeat timing constants.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Defaults assume a 50 MHz system clock.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/button_conditioner_if.sv
// Button signal bundle: raw active-low input plus the conditioned level and strobes.
interface button_conditioner_if;

    logic btn_raw_n;
    logic btn_clean_n;
    logic press_pulse;
    logic release_pulse;

    modport master (
        output btn_raw_n,
        input  btn_clean_n,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw_n,
        output btn_clean_n,
        output press_pulse,
        output release_pulse
    );

endinterface

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; both flops reset to 1
// so an active-low input reads as inactive out of reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces one active-low push-button, producing a clean level
// plus one-cycle press/release strobes. Define BUTTON_CONDITIONER_AUTOREPEAT_EN for auto-repeat.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    button_conditioner_if.slave btn
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) ||
        (REPEAT_DELAY < 1) || (REPEAT_DELAY > (2 ** CNT_W) - 1) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > (2 ** CNT_W) - 1)) begin : g_param_check
        $error("button_conditioner: timing parameter out of range for CNT_W");
    end

    logic       s;
    btn_state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic       clean_n_q;
    logic       press_q;
    logic       release_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn.btn_raw_n),
        .q_o   (s)
    );

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rep_q selects the first (long) delay vs. the steady repeat period.
    logic [CNT_W-1:0] rpt_q;
    logic             rep_q;
    logic [CNT_W-1:0] rpt_last;

    always_comb begin
        rpt_last = rep_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clean_n_q <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rpt_q     <= '0;
            rep_q     <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= HELD;
                        cnt_q     <= '0;
                        clean_n_q <= 1'b0;
                        press_q   <= 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                        rpt_q     <= '0;
                        rep_q     <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    // Repeat timing pauses (not restarts) across a rejected release bounce.
                    else if (rpt_q == rpt_last) begin
                        press_q <= 1'b1;
                        rpt_q   <= '0;
                        rep_q   <= 1'b1;
                    end else begin
                        rpt_q <= rpt_q + CNT_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        clean_n_q <= 1'b1;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign btn.btn_clean_n   = clean_n_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic c, input logic p, input logic r);
        checks++;
        assert (bif.btn_clean_n === c) else begin
            errors++;
            $error("FAIL %s clean_n: got %b want %b", tag, bif.btn_clean_n, c);
        end
        checks++;
        assert (bif.press_pulse === p) else begin
            errors++;
            $error("FAIL %s press: got %b want %b", tag, bif.press_pulse, p);
        end
        checks++;
        assert (bif.release_pulse === r) else begin
            errors++;
            $error("FAIL %s release: got %b want %b", tag, bif.release_pulse, r);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bif.btn_raw_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // Clean press: accepted at edge 7
        bif.btn_raw_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("press_wait_%0d", i), 1'b1, 1'b0, 1'b0);
        end
        step();
        check("press_accept", 1'b0, 1'b1, 1'b0);
        step();
        check("press_after", 1'b0, 1'b0, 1'b0);

        // Clean release: accepted at edge 7
        bif.btn_raw_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("rel_wait_%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step();
        check("rel_accept", 1'b1, 1'b0, 1'b1);
        step();
        check("rel_after", 1'b1, 1'b0, 1'b0);

        // Bounce: low 3, high 1, low held; accepted 7 edges after last fall (edge 11)
        bif.btn_raw_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("bounce_%0d", i), 1'b1, 1'b0, 1'b0);
        end
        bif.btn_raw_n = 1'b1;
        step();
        check("bounce_4", 1'b1, 1'b0, 1'b0);
        bif.btn_raw_n = 1'b0;
        for (int i = 5; i <= 10; i++) begin
            step();
            check($sformatf("bounce_%0d", i), 1'b1, 1'b0, 1'b0);
        end
        step();
        check("bounce_accept", 1'b0, 1'b1, 1'b0);
        step();
        check("bounce_after", 1'b0, 1'b0, 1'b0);

        // Release glitch while HELD: 2 cycles high then low
        bif.btn_raw_n = 1'b1;
        step();
        check("glitch_1", 1'b0, 1'b0, 1'b0);
        step();
        check("glitch_2", 1'b0, 1'b0, 1'b0);
        bif.btn_raw_n = 1'b0;
        for (int i = 3; i <= 6; i++) begin
            step();
            check($sformatf("glitch_%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Full release after glitch
        bif.btn_raw_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("rel2_wait_%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step();
        check("rel2_accept", 1'b1, 1'b0, 1'b1);
        step();
        check("rel2_after", 1'b1, 1'b0, 1'b0);

        // Reset in PRESS_WAIT at cnt==2 with raw held low
        bif.btn_raw_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("rpw_%0d", i), 1'b1, 1'b0, 1'b0);
        end
        reset = 1'b1;
        #1;
        check("rpw_reset_now", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rpw_reset_hold", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("rpw_after_%0d", i), 1'b1, 1'b0, 1'b0);
        end
        step();
        check("rpw_accept", 1'b0, 1'b1, 1'b0);

        // Hold 20 cycles after acceptance: repeats at +10,+13,+16,+19 only when enabled
        for (int j = 1; j <= 20; j++) begin
            step();
            check($sformatf("hold_%0d", j), 1'b0,
                  RPT_ON && (j == 10 || j == 13 || j == 16 || j == 19), 1'b0);
        end

        // Reset while HELD: level returns to released at once, no strobe afterwards
        reset = 1'b1;
        #1;
        check("rheld_now", 1'b1, 1'b0, 1'b0);
        bif.btn_raw_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("rheld_after_%0d", i), 1'b1, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for every player/menu push-button in the Pong design. Takes a raw, asynchronous, active-low board button, synchronizes it, and debounces it with a per-button state machine. Produces a clean active-low level and single-cycle press/release strobes. The clean level drives the colour-stepping and paddle-control logic directly downstream; the strobes feed edge-triggered consumers.

## Interface
- DEBOUNCE_CYCLES, 500000 — consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); legal range 2..2^CNT_W−1
- REPEAT_DELAY, 25000000 — HELD cycles before the first auto-repeat strobe (only with macro)
- REPEAT_PERIOD, 5000000 — cycles between subsequent auto-repeat strobes (only with macro)
- CNT_W, 25 — width of the debounce and repeat counters; must hold the largest of the three counts
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_raw_n  input  1  raw board button, active-low, asynchronous to clk
- btn_clean_n  output  1  debounced level, active-low; reset value 1
- press_pulse  output  1  one-cycle strobe on accepted press (and on auto-repeat); reset value 0
- release_pulse  output  1  one-cycle strobe on accepted release; reset value 0

## Operation
- Two-flop synchronizer on btn_raw_n, both flops reset to 1 (released); its output is s.
- One debounce counter cnt (CNT_W bits), cleared on every state entry.
- FSM states and transitions:
  - IDLE (stable released): s==0 → PRESS_WAIT.
  - PRESS_WAIT: s==1 → IDLE (bounce rejected, no output change). s==0 and cnt==DEBOUNCE_CYCLES−1 → HELD, with btn_clean_n←0 and press_pulse←1 for one cycle. Otherwise cnt+1.
  - HELD (stable pressed): s==1 → RELEASE_WAIT.
  - RELEASE_WAIT: s==0 → HELD (bounce rejected, no strobe, btn_clean_n stays 0). s==1 and cnt==DEBOUNCE_CYCLES−1 → IDLE, with btn_clean_n←1 and release_pulse←1 for one cycle. Otherwise cnt+1.
- All outputs are registered. press_pulse and release_pulse are never high in the same cycle.
- Counters never wrap. The terminal compare fires before overflow, given the legal parameter range.
- Reset, asserted at any time including mid-count: FSM→IDLE, cnt←0, synchronizer←1, outputs at reset values. A button still held low at reset release is accepted as a new press after the full debounce latency. No strobe is emitted on reset.

## Timing
- Raw edge stable before clk edge 1: s changes after edge 2, state leaves IDLE/HELD at edge 3, and btn_clean_n plus the strobe update at edge DEBOUNCE_CYCLES+3.
- Any s reversal during a WAIT state restarts the full DEBOUNCE_CYCLES window on the next attempt.
- Strobes are exactly one clk wide. The minimum spacing between press_pulse and release_pulse is DEBOUNCE_CYCLES+1 cycles.

## Configuration
- BUTTON_CONDITIONER_AUTOREPEAT_EN defined:
  - A repeat counter runs only in HELD. It is cleared on HELD entry from PRESS_WAIT and held, not cleared, while in RELEASE_WAIT.
  - press_pulse fires REPEAT_DELAY cycles after HELD entry, then every REPEAT_PERIOD cycles while still HELD.
  - Leaving HELD via a full release cancels repeats.
- Macro undefined: the repeat counter and its logic are absent. press_pulse fires exactly once per accepted press.

## Structure
- Shared package: the FSM state encoding (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT as a 2-bit typedef) and the default debounce/repeat constants, shared with the other input-side blocks.
- One sub-module, sync_2ff: a reset-to-1 two-flop synchronizer. It is reused for every asynchronous board input.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btn_raw_n 1→0 held → btn_clean_n falls and press_pulse is high for one cycle at edge 7; release 0→1 held → btn_clean_n rises and release_pulse fires at edge 7 after the release.
- Bounce: raw low for 3 cycles, high 1 cycle, then low held → no output change until 7 edges after the last falling edge; exactly one press_pulse.
- Release glitch: while HELD, raw high for 2 cycles then low → btn_clean_n stays 0, no release_pulse.
- Reset mid-PRESS_WAIT: assert reset at cnt==2 with raw held low → outputs read 1/0/0 immediately. After deassert, press is accepted 7 edges later with one press_pulse.
- Auto-repeat (macro on): hold the press for 20 cycles after acceptance → extra press_pulses at HELD+10, +13, +16, +19. With the macro off, only the initial press_pulse is seen.
